// File: rtl/sipo_frame_receiver_if.sv
// Serial link plus word-side handshake for the SIPO frame receiver.
// Handshake rule: a word moves from receiver to consumer on every rising
// clk edge where out_valid=1 and out_ready=1; out_valid never depends on
// out_ready in the same cycle, and parallel_out is stable while out_valid=1
// and out_ready=0.
interface sipo_frame_receiver_if #(
    parameter int WIDTH = 4
);
    logic             serial_in;
    logic             bit_en;
    logic [WIDTH-1:0] parallel_out;
    logic             out_valid;
    logic             out_ready;
    logic             frame_err;
    logic             overrun;

    // Upstream serializer plus downstream consumer side.
    modport master (
        output serial_in,
        output bit_en,
        output out_ready,
        input  parallel_out,
        input  out_valid,
        input  frame_err,
        input  overrun
    );

    // Receiver side.
    modport slave (
        input  serial_in,
        input  bit_en,
        input  out_ready,
        output parallel_out,
        output out_valid,
        output frame_err,
        output overrun
    );
endinterface

// File: rtl/sipo_frame_receiver.sv
// Serial-to-parallel frame receiver: start bit (1), WIDTH data bits, stop
// bit (0), all sampled on bit_en. Good words go into a one-entry
// valid/ready buffer; bad stop bits and dropped words are reported as
// one-cycle pulses.
module sipo_frame_receiver #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    sipo_frame_receiver_if.slave   link,
    output logic [1:0]             state_dbg
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [WIDTH-1:0] word_q;
    logic             valid_q;
    logic             frame_err_q;
    logic             overrun_q;

    logic             last_bit;
    logic             good_stop;
    logic             bad_stop;
    logic             drain;
    logic             load;

    assign last_bit  = (cnt_q == CW'(WIDTH - 1));
    assign good_stop = (state_q == STOP) && link.bit_en && !link.serial_in;
    assign bad_stop  = (state_q == STOP) && link.bit_en && link.serial_in;
    assign drain     = valid_q && link.out_ready;
    // A good word is accepted when the buffer is empty or drains this edge.
    assign load      = good_stop && (!valid_q || link.out_ready);

    // Next-state, counter and shift-register logic; nothing moves without bit_en.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        if (link.bit_en) begin
            case (state_q)
                IDLE: begin
                    if (link.serial_in) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    if (MSB_FIRST) begin
                        shreg_d = {shreg_q[WIDTH-2:0], link.serial_in};
                    end else begin
                        shreg_d = {link.serial_in, shreg_q[WIDTH-1:1]};
                    end
                    if (last_bit) begin
                        state_d = STOP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    // A stop bit of 1 is never reused as a start bit.
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Frame state, bit counter and shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    // One-entry output buffer and the error pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= bad_stop;
            overrun_q   <= good_stop && !load;
            if (load) begin
                word_q  <= shreg_q;
                valid_q <= 1'b1;
            end else if (drain) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign link.parallel_out = word_q;
    assign link.out_valid    = valid_q;
    assign link.frame_err    = frame_err_q;
    assign link.overrun      = overrun_q;
    assign state_dbg         = state_q;

endmodule

// File: tb/tb_sipo_frame_receiver.sv
// Bench for sipo_frame_receiver: an MSB-first and an LSB-first instance
// share one stimulus stream. A frame-level reference model (bit queue plus
// a one-entry expected-word queue) is checked every cycle; a vector table
// and hand-written sequences add fixed expected values.
module tb_sipo_frame_receiver;

    localparam int W = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic serial_in = 1'b0;
    logic bit_en    = 1'b0;
    logic out_ready = 1'b0;
    logic [1:0] dbg_m;
    logic [1:0] dbg_l;

    sipo_frame_receiver_if #(.WIDTH(W)) if_m ();
    sipo_frame_receiver_if #(.WIDTH(W)) if_l ();

    assign if_m.serial_in = serial_in;
    assign if_m.bit_en    = bit_en;
    assign if_m.out_ready = out_ready;
    assign if_l.serial_in = serial_in;
    assign if_l.bit_en    = bit_en;
    assign if_l.out_ready = out_ready;

    sipo_frame_receiver #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk       (clk),
        .reset     (reset),
        .link      (if_m),
        .state_dbg (dbg_m)
    );

    sipo_frame_receiver #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk       (clk),
        .reset     (reset),
        .link      (if_l),
        .state_dbg (dbg_l)
    );

    // ---------------- scoreboard / reference model ----------------
    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];   // words the buffer should hold (0 or 1 entry)
    logic         fbits[$];   // bits of the frame in flight, after the start bit
    logic         in_frame = 1'b0;
    logic         e_err = 1'b0;
    logic         e_ovr = 1'b0;

    int  ready_mode = 1;      // 0: never, 1: always, 2: random, 3: stop strobe only
    logic on_stop = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[W-1-i];
        return r;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        fbits.delete();
        in_frame = 1'b0;
        e_err = 1'b0;
        e_ovr = 1'b0;
    endtask

    // Predict the effect of the coming edge from the current inputs.
    task automatic model_step();
        logic [W-1:0] word;
        e_err = 1'b0;
        e_ovr = 1'b0;
        if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
        if (bit_en) begin
            if (!in_frame) begin
                if (serial_in) begin
                    in_frame = 1'b1;
                    fbits.delete();
                end
            end else begin
                fbits.push_back(serial_in);
                if (fbits.size() == W + 1) begin
                    in_frame = 1'b0;
                    for (int i = 0; i < W; i++) word[W-1-i] = fbits[i];
                    if (fbits[W]) e_err = 1'b1;
                    else if (exp_q.size() == 0) exp_q.push_back(word);
                    else e_ovr = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic exp_v;
        exp_v = (exp_q.size() != 0);
        chk("m_valid", 32'(if_m.out_valid), 32'(exp_v));
        chk("l_valid", 32'(if_l.out_valid), 32'(exp_v));
        chk("m_frame_err", 32'(if_m.frame_err), 32'(e_err));
        chk("l_frame_err", 32'(if_l.frame_err), 32'(e_err));
        chk("m_overrun", 32'(if_m.overrun), 32'(e_ovr));
        chk("l_overrun", 32'(if_l.overrun), 32'(e_ovr));
        if (exp_v) begin
            chk("m_word", 32'(if_m.parallel_out), 32'(exp_q[0]));
            chk("l_word", 32'(if_l.parallel_out), 32'(rev(exp_q[0])));
        end
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_m_word"}, 32'(if_m.parallel_out), 32'd0);
        chk({name, "_l_word"}, 32'(if_l.parallel_out), 32'd0);
        chk({name, "_m_valid"}, 32'(if_m.out_valid), 32'd0);
        chk({name, "_l_valid"}, 32'(if_l.out_valid), 32'd0);
        chk({name, "_m_err"}, 32'(if_m.frame_err), 32'd0);
        chk({name, "_m_ovr"}, 32'(if_m.overrun), 32'd0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input logic en, input logic sin);
        bit_en    = en;
        serial_in = sin;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = on_stop;
        endcase
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Start bit, data MSB first, stop bit; `gap` idle cycles with noise before each strobe.
    task automatic send_frame(input logic [W-1:0] data, input logic stop, input int gap);
        logic [W+1:0] bits;
        bits = {1'b1, data, stop};
        for (int i = W + 1; i >= 0; i--) begin
            for (int g = 0; g < gap; g++) tick(1'b0, 1'($urandom_range(0, 1)));
            on_stop = (i == 0);
            tick(1'b1, bits[i]);
        end
        on_stop = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        model_reset();
        check_all_zero("reset_async");
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all_zero("reset_hold");
        reset = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [W-1:0] data;
        logic         stop;
        logic [W-1:0] exp_msb;
        logic [W-1:0] exp_lsb;
        logic         exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{4'b1011, 1'b0, 4'b1011, 4'b1101, 1'b0};
        vecs[1] = '{4'b0101, 1'b0, 4'b0101, 4'b1010, 1'b0};
        vecs[2] = '{4'b1000, 1'b0, 4'b1000, 4'b0001, 1'b0};
        vecs[3] = '{4'b1011, 1'b1, 4'b0000, 4'b0000, 1'b1};
        vecs[4] = '{4'b1110, 1'b0, 4'b1110, 4'b0111, 1'b0};
        vecs[5] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0};

        // Reset at time zero.
        #1;
        do_reset();
        tick(1'b0, 1'b0);

        // Reset mid-frame: start + 2 data bits, then reset, then a clean frame.
        ready_mode = 1;
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        do_reset();
        send_frame(4'b1011, 1'b0, 0);
        chk("after_reset_word", 32'(if_m.parallel_out), 32'h0000000b);

        // Basic frames: out_valid high for exactly one cycle with out_ready=1.
        tick(1'b0, 1'b0);
        chk("basic_valid_drop", 32'(if_m.out_valid), 32'd0);
        send_frame(4'b0101, 1'b0, 0);
        chk("basic_word2", 32'(if_m.parallel_out), 32'h00000005);

        // Table-driven frames.
        for (int v = 0; v < 6; v++) begin
            ready_mode = 1;
            send_frame(vecs[v].data, vecs[v].stop, 0);
            chk("tbl_err", 32'(if_m.frame_err), 32'(vecs[v].exp_err));
            chk("tbl_valid", 32'(if_m.out_valid), 32'(!vecs[v].exp_err));
            if (!vecs[v].exp_err) begin
                chk("tbl_msb", 32'(if_m.parallel_out), 32'(vecs[v].exp_msb));
                chk("tbl_lsb", 32'(if_l.parallel_out), 32'(vecs[v].exp_lsb));
            end
            tick(1'b0, 1'b0);
        end

        // Strobe gaps: bit_en every third cycle, noise in between.
        send_frame(4'b1011, 1'b0, 2);
        chk("gap_word", 32'(if_m.parallel_out), 32'h0000000b);
        chk("gap_valid", 32'(if_m.out_valid), 32'd1);
        tick(1'b0, 1'b0);

        // Framing error followed by a good frame.
        send_frame(4'b1011, 1'b1, 0);
        chk("ferr_pulse", 32'(if_m.frame_err), 32'd1);
        chk("ferr_valid", 32'(if_m.out_valid), 32'd0);
        tick(1'b0, 1'b0);
        chk("ferr_one_cycle", 32'(if_m.frame_err), 32'd0);
        send_frame(4'b0101, 1'b0, 0);
        chk("ferr_next_word", 32'(if_m.parallel_out), 32'h00000005);
        tick(1'b0, 1'b0);

        // Overrun with the buffer held, then load on a draining edge.
        ready_mode = 0;
        send_frame(4'b1011, 1'b0, 0);
        send_frame(4'b0101, 1'b0, 0);
        chk("ovr_pulse", 32'(if_m.overrun), 32'd1);
        chk("ovr_held_word", 32'(if_m.parallel_out), 32'h0000000b);
        tick(1'b0, 1'b0);
        chk("ovr_one_cycle", 32'(if_m.overrun), 32'd0);
        chk("ovr_still_held", 32'(if_m.parallel_out), 32'h0000000b);
        ready_mode = 3;
        send_frame(4'b0101, 1'b0, 0);
        chk("drain_load_word", 32'(if_m.parallel_out), 32'h00000005);
        chk("drain_load_valid", 32'(if_m.out_valid), 32'd1);
        chk("drain_load_ovr", 32'(if_m.overrun), 32'd0);
        ready_mode = 1;
        tick(1'b0, 1'b0);

        // Back-to-back frames with random gaps, stops, idles and consumer.
        for (int n = 0; n < 200; n++) begin
            ready_mode = 2;
            send_frame(W'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 2));
            for (int k = $urandom_range(0, 2); k > 0; k--) tick(1'($urandom_range(0, 1)), 1'b0);
        end

        // Random reset in the middle of traffic, then one known frame.
        ready_mode = 1;
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        do_reset();
        send_frame(4'b1000, 1'b0, 1);
        chk("final_msb", 32'(if_m.parallel_out), 32'h00000008);
        chk("final_lsb", 32'(if_l.parallel_out), 32'h00000001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
